// File: rtl/ldvio_vld_ctrl_pkg.sv
// Shared definitions for the load-violation valid-table write controller.
package ldvio_vld_ctrl_pkg;

   localparam logic VLD_SET = 1'b1;
   localparam logic VLD_CLR = 1'b0;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } vld_state_e;

endpackage

// File: rtl/ldvio_set_fifo.sv
// Synchronous FIFO buffering set requests; supports push and pop in one cycle.
module ldvio_set_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] pop_data_o,
   output logic         full_o,
   output logic         empty_o
);
   import ldvio_vld_ctrl_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign full_o     = (r_count == CNT_W'(DEPTH));
   assign empty_o    = (r_count == '0);
   assign pop_data_o = r_mem[r_rd_ptr];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign w_pop  = pop_i & !empty_o;
   assign w_push = push_i & (!full_o | w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ldvio_vld_ctrl.sv
// Write-port arbiter for the load-violation valid table: clears, buffered sets
// and a full-table decay/flush sweep share one registered RAM write port.
module ldvio_vld_ctrl #(
   parameter int unsigned           DEPTH          = 16,
   parameter int unsigned           INDEX          = 4,
   parameter int unsigned           WIDTH          = 8,
   parameter int unsigned           SET_FIFO_DEPTH = 4,
   parameter int unsigned           DECAY_BITS     = 16,
   parameter logic [DECAY_BITS-1:0] DECAY_PERIOD   = 16'd40000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             set_valid_i,
   input  logic [INDEX-1:0] set_addr_i,
   output logic             set_ready_o,
   input  logic             clr_valid_i,
   input  logic [INDEX-1:0] clr_addr_i,
   input  logic             flush_i,
   output logic [INDEX-1:0] addr0wr_o,
   output logic [WIDTH-1:0] data0wr_o,
   output logic             we0_o,
   output logic             sweep_busy_o,
   output logic [7:0]       set_drop_cnt_o
);
   import ldvio_vld_ctrl_pkg::*;

   vld_state_e            r_state;
   logic [INDEX-1:0]      r_idx;
   logic [DECAY_BITS-1:0] r_timer;
   logic [INDEX-1:0]      r_addr;
   logic [WIDTH-1:0]      r_data;
   logic                  r_we;
   logic                  r_busy;
   logic [7:0]            r_drop;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic [INDEX-1:0]      w_head;
   logic                  w_decay_hit;

   assign set_ready_o = !w_full;
   assign w_push      = set_valid_i & !w_full;
   // Sets drain only in IDLE and only when no clear claims the port.
   assign w_pop       = (r_state == IDLE) & !clr_valid_i & !w_empty;
   assign w_decay_hit = (DECAY_PERIOD != '0) &&
                        (r_timer == DECAY_PERIOD - DECAY_BITS'(1));

   ldvio_set_fifo #(
      .DEPTH (SET_FIFO_DEPTH),
      .W     (INDEX)
   ) u_set_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (w_push),
      .push_data_i (set_addr_i),
      .pop_i       (w_pop),
      .pop_data_o  (w_head),
      .full_o      (w_full),
      .empty_o     (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_timer <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_we    <= 1'b0;
         r_busy  <= 1'b0;
         r_drop  <= '0;
      end else begin
         r_we <= 1'b0;
         if (set_valid_i && w_full && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
         end
         case (r_state)
            IDLE: begin
               r_timer <= r_timer + DECAY_BITS'(1);
               if (clr_valid_i) begin
                  r_we   <= 1'b1;
                  r_addr <= clr_addr_i;
                  r_data <= WIDTH'(VLD_CLR);
               end else if (!w_empty) begin
                  r_we   <= 1'b1;
                  r_addr <= w_head;
                  r_data <= WIDTH'(VLD_SET);
               end
               // Arbitration above still happens in the transition cycle.
               if (flush_i || w_decay_hit) begin
                  r_state <= SWEEP;
                  r_busy  <= 1'b1;
                  r_idx   <= '0;
                  r_timer <= '0;
               end
            end
            SWEEP: begin
               r_we   <= 1'b1;
               r_addr <= r_idx;
               r_data <= WIDTH'(VLD_CLR);
               if (flush_i) begin
                  r_idx <= '0;
               end else if (r_idx == INDEX'(DEPTH - 1)) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_idx <= r_idx + INDEX'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign addr0wr_o      = r_addr;
   assign data0wr_o      = r_data;
   assign we0_o          = r_we;
   assign sweep_busy_o   = r_busy;
   assign set_drop_cnt_o = r_drop;

endmodule

// File: tb/tb_ldvio_vld_ctrl.sv
// Directed bench: vector table for arbitration/FIFO, plus flush and decay sequences.
module tb_ldvio_vld_ctrl;

   logic       clk;
   logic       reset_n;
   logic       set_v;
   logic [3:0] set_a;
   logic       set_rdy;
   logic       clr_v;
   logic [3:0] clr_a;
   logic       flush;
   logic [3:0] wr_a;
   logic [7:0] wr_d;
   logic       wr_e;
   logic       busy;
   logic [7:0] drop;

   logic       rst_dec_n;
   logic       d_clr_v;
   logic [3:0] d_clr_a;
   logic       d_rdy;
   logic [3:0] d_wr_a;
   logic [7:0] d_wr_d;
   logic       d_wr_e;
   logic       d_busy;
   logic [7:0] d_drop;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       sv;
      logic [3:0] sa;
      logic       cv;
      logic [3:0] ca;
      logic       ew;
      logic [3:0] ea;
      logic [7:0] ed;
      logic       er;
      logic [7:0] edr;
   } vec_t;

   vec_t vecs[32];
   int   n_vec = 0;

   ldvio_vld_ctrl #(.DECAY_PERIOD(16'd0)) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .set_valid_i    (set_v),
      .set_addr_i     (set_a),
      .set_ready_o    (set_rdy),
      .clr_valid_i    (clr_v),
      .clr_addr_i     (clr_a),
      .flush_i        (flush),
      .addr0wr_o      (wr_a),
      .data0wr_o      (wr_d),
      .we0_o          (wr_e),
      .sweep_busy_o   (busy),
      .set_drop_cnt_o (drop)
   );

   ldvio_vld_ctrl #(.DECAY_PERIOD(16'd20)) u_dec (
      .clk            (clk),
      .reset_n        (rst_dec_n),
      .set_valid_i    (1'b0),
      .set_addr_i     (4'd0),
      .set_ready_o    (d_rdy),
      .clr_valid_i    (d_clr_v),
      .clr_addr_i     (d_clr_a),
      .flush_i        (1'b0),
      .addr0wr_o      (d_wr_a),
      .data0wr_o      (d_wr_d),
      .we0_o          (d_wr_e),
      .sweep_busy_o   (d_busy),
      .set_drop_cnt_o (d_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic check_dut(input string nm, input int idx, input logic ew,
                            input logic [3:0] ea, input logic [7:0] ed, input logic er,
                            input logic eb, input logic [7:0] edr);
      chk({nm, ".we"},    idx, 32'(wr_e),    32'(ew));
      chk({nm, ".addr"},  idx, 32'(wr_a),    32'(ea));
      chk({nm, ".data"},  idx, 32'(wr_d),    32'(ed));
      chk({nm, ".ready"}, idx, 32'(set_rdy), 32'(er));
      chk({nm, ".busy"},  idx, 32'(busy),    32'(eb));
      chk({nm, ".drop"},  idx, 32'(drop),    32'(edr));
   endtask

   task automatic check_dec(input string nm, input int idx, input logic ew,
                            input logic [3:0] ea, input logic eb);
      chk({nm, ".we"},    idx, 32'(d_wr_e), 32'(ew));
      chk({nm, ".addr"},  idx, 32'(d_wr_a), 32'(ea));
      chk({nm, ".data"},  idx, 32'(d_wr_d), 32'd0);
      chk({nm, ".busy"},  idx, 32'(d_busy), 32'(eb));
      chk({nm, ".ready"}, idx, 32'(d_rdy),  32'd1);
      chk({nm, ".drop"},  idx, 32'(d_drop), 32'd0);
   endtask

   task automatic add(input logic sv, input logic [3:0] sa, input logic cv,
                      input logic [3:0] ca, input logic ew, input logic [3:0] ea,
                      input logic [7:0] ed, input logic er, input logic [7:0] edr);
      vecs[n_vec] = '{sv, sa, cv, ca, ew, ea, ed, er, edr};
      n_vec++;
   endtask

   // Timer runs 20 quiet cycles from reset release, then sweeps nsweep entries.
   task automatic dec_run(input string nm, input int nsweep);
      for (int c = 1; c <= 20; c++) begin
         tick();
         check_dec({nm, ".wait"}, c, 1'b0, 4'd0, (c == 20));
      end
      for (int k = 0; k < nsweep; k++) begin
         d_clr_v = (k == 4);
         d_clr_a = 4'd9;
         tick();
         d_clr_v = 1'b0;
         check_dec({nm, ".sweep"}, k, 1'b1, 4'(k), (k < 15));
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      rst_dec_n = 1'b0;
      set_v = 1'b0; set_a = '0; clr_v = 1'b0; clr_a = '0; flush = 1'b0;
      d_clr_v = 1'b0; d_clr_a = '0;

      //   sv  sa   cv  ca    ew  ea   ed  er  drop
      add(0, 0,   0, 0,    0, 0,   0,  1,  0);
      add(1, 5,   0, 0,    0, 0,   0,  1,  0);
      add(0, 0,   0, 0,    1, 5,   1,  1,  0);
      add(0, 0,   0, 0,    0, 5,   1,  1,  0);
      add(1, 7,   0, 0,    0, 5,   1,  1,  0);
      add(0, 0,   1, 3,    1, 3,   0,  1,  0);
      add(0, 0,   0, 0,    1, 7,   1,  1,  0);
      add(0, 0,   0, 0,    0, 7,   1,  1,  0);
      add(1, 9,   1, 9,    1, 9,   0,  1,  0);
      add(0, 0,   0, 0,    1, 9,   1,  1,  0);
      add(0, 0,   0, 0,    0, 9,   1,  1,  0);
      add(1, 2,   0, 0,    0, 9,   1,  1,  0);
      add(0, 0,   1, 4,    1, 4,   0,  1,  0);
      add(0, 0,   1, 6,    1, 6,   0,  1,  0);
      add(0, 0,   0, 0,    1, 2,   1,  1,  0);
      add(0, 0,   0, 0,    0, 2,   1,  1,  0);
      add(1, 1,   1, 0,    1, 0,   0,  1,  0);
      add(1, 2,   1, 0,    1, 0,   0,  1,  0);
      add(1, 3,   1, 0,    1, 0,   0,  1,  0);
      add(1, 4,   1, 0,    1, 0,   0,  0,  0);
      add(1, 8,   1, 0,    1, 0,   0,  0,  1);
      add(0, 0,   0, 0,    1, 1,   1,  1,  1);
      add(0, 0,   0, 0,    1, 2,   1,  1,  1);
      add(0, 0,   0, 0,    1, 3,   1,  1,  1);
      add(0, 0,   0, 0,    1, 4,   1,  1,  1);
      add(0, 0,   0, 0,    0, 4,   1,  1,  1);

      tick();
      tick();
      check_dut("reset", 0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 8'd0);
      reset_n = 1'b1;

      for (int i = 0; i < n_vec; i++) begin
         set_v = vecs[i].sv; set_a = vecs[i].sa;
         clr_v = vecs[i].cv; clr_a = vecs[i].ca;
         tick();
         check_dut("vec", i, vecs[i].ew, vecs[i].ea, vecs[i].ed, vecs[i].er,
                   1'b0, vecs[i].edr);
      end
      set_v = 1'b0; clr_v = 1'b0;

      // Reset clears held write address/data and drop count.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_dut("rst2", 0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 8'd0);

      // Flush with a set in the same cycle, more sets and a clear during the sweep.
      flush = 1'b1; set_v = 1'b1; set_a = 4'd10;
      tick();
      flush = 1'b0; set_v = 1'b0;
      check_dut("flush", 0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 8'd0);
      for (int k = 0; k < 16; k++) begin
         set_v = (k < 4);
         set_a = 4'(11 + k);
         clr_v = (k == 5);
         clr_a = 4'd12;
         tick();
         check_dut("sweep", k, 1'b1, 4'(k), 8'd0, (k < 2), (k < 15), 8'((k >= 3) ? 1 : 0));
      end
      set_v = 1'b0; clr_v = 1'b0;
      for (int j = 0; j < 4; j++) begin
         tick();
         check_dut("drain", j, 1'b1, 4'(10 + j), 8'd1, 1'b1, 1'b0, 8'd1);
      end
      tick();
      check_dut("post", 0, 1'b0, 4'd13, 8'd1, 1'b1, 1'b0, 8'd1);

      // Automatic decay, reset abandoning the sweep at index 6, then a full rerun.
      tick();
      check_dec("dec_rst", 0, 1'b0, 4'd0, 1'b0);
      rst_dec_n = 1'b1;
      dec_run("dec_a", 6);
      rst_dec_n = 1'b0;
      tick();
      rst_dec_n = 1'b1;
      check_dec("dec_mid_rst", 0, 1'b0, 4'd0, 1'b0);
      dec_run("dec_b", 16);
      tick();
      check_dec("dec_done", 0, 1'b0, 4'd15, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ldvio_vld_ctrl.md
Name: ldvio_vld_ctrl

Overview:
- Write-port controller for the load-violation valid-bit table. The table is a DEPTH-entry RAM with one write port. Dispatch reads it on DISPATCH_WIDTH read ports, and those reads are unaffected by this block.
- Three requesters share the single write port:
  - set requests from the LSU violation detector (mark entry valid);
  - clear requests from commit-time training (mark entry invalid);
  - a decay/flush sweep that zeroes every entry, one per cycle.
- The block owns arbitration, buffering of set requests, and the sweep sequencing. All RAM write-port signals are registered.

Parameters:
- DEPTH, 16, number of table entries.
- INDEX, 4, log2(DEPTH); width of all table addresses.
- WIDTH, 8, table entry width. A set writes WIDTH'(1); a clear or sweep writes WIDTH'(0).
- SET_FIFO_DEPTH, 4, entries in the set-request buffer (power of 2, ≥2).
- DECAY_BITS, 16, width of the decay timer.
- DECAY_PERIOD, 16'd40000, cycles between automatic sweeps. A value of 0 disables automatic decay.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- set_valid_i  in  1  set request valid.
- set_addr_i  in  INDEX  entry to mark valid.
- set_ready_o  out  1  set buffer can accept a request; handshake is set_valid_i & set_ready_o.
- clr_valid_i  in  1  clear request; always accepted, no ready.
- clr_addr_i  in  INDEX  entry to mark invalid.
- flush_i  in  1  one-cycle pulse that starts an immediate full sweep.
- addr0wr_o  out  INDEX  RAM write address.
- data0wr_o  out  WIDTH  RAM write data.
- we0_o  out  1  RAM write enable.
- sweep_busy_o  out  1  high while in the SWEEP state.
- set_drop_cnt_o  out  8  saturating count of set requests offered while set_ready_o was low.

Behaviour:
- Reset (reset_n low at a rising edge):
  - FSM goes to IDLE; FIFO emptied; sweep index and decay timer cleared to 0.
  - we0_o=0, addr0wr_o=0, data0wr_o=0, sweep_busy_o=0, set_drop_cnt_o=0.
  - set_ready_o=1 from the first cycle after reset deasserts.
  - Reset mid-sweep abandons the sweep; entries not yet swept are left as they are.
- FSM states:
  - IDLE → SWEEP when flush_i=1, or when DECAY_PERIOD≠0 and the timer equals DECAY_PERIOD-1. On entry the sweep index is set to 0 and the timer to 0.
  - SWEEP → IDLE in the cycle after the write to index DEPTH-1 is issued.
  - flush_i while in SWEEP restarts the sweep index at 0.
- Decay timer: increments by 1 each cycle in IDLE and is frozen in SWEEP.
- Arbitration (evaluated in cycle N, write outputs registered and visible in N+1):
  - SWEEP: the sweep owns the port. It writes index i with 0 and increments i.
    - Clear requests arriving in SWEEP are discarded; they are redundant because the sweep clears everything.
    - The set FIFO does not drain but still accepts requests while not full.
  - IDLE, priority 1: clr_valid_i. Write clr_addr_i with 0.
  - IDLE, priority 2: non-empty FIFO. Pop the head and write its address with WIDTH'(1).
  - IDLE, neither: we0_o=0. addr0wr_o and data0wr_o hold their last values.
- Set latency: a set accepted at cycle N enters the FIFO at N+1 and, if uncontended, appears on the write port at N+2.
- Set FIFO:
  - set_ready_o = !full. This is combinational on the FIFO count only and does not depend on set_valid_i.
  - Push and pop in the same cycle are allowed when full; the count is unchanged.
  - Pointers wrap modulo SET_FIFO_DEPTH.
  - An offered-but-refused set increments set_drop_cnt_o, which saturates at 255.
- Ordering: a set and a clear to the same address in the same cycle both take effect in arbitration order. The clear writes first and the set follows later, so the final value is valid.
- Timer transition: the cycle in which the timer transitions IDLE→SWEEP still performs its IDLE arbitration. Sweep writes begin the following cycle.

Decomposition:
- Shared package: entry-valid encoding (VLD_SET/VLD_CLR constants) and the FSM state typedef (IDLE, SWEEP).
- Sub-module ldvio_set_fifo: parameterised sync FIFO with count, full/empty, and simultaneous push/pop.
- The controller FSM, timer and arbiter are implemented in ldvio_vld_ctrl itself.

Test Plan:
- Reset then idle: expect all outputs 0, set_ready_o=1, no we0_o for DECAY_PERIOD-1 cycles.
- Set addr 5 at cycle 10, no contention: expect we0_o=1, addr0wr_o=5, data0wr_o=1 at cycle 12.
- Clear addr 3 and queued set addr 7 in the same cycle: expect write (3,0) first, then (7,1) the next cycle.
- flush_i with DEPTH=16: sweep_busy_o high 16 cycles, writes (0,0)…(15,0) on consecutive cycles. Sets offered meanwhile fill the FIFO: 4 accepted, the 5th refused, set_drop_cnt_o=1. After the sweep, the 4 buffered sets drain in FIFO order.
- DECAY_PERIOD=20: automatic sweep begins 21 cycles after reset release. A clear arriving mid-sweep produces no extra write.
- reset_n low at sweep index 6: expect outputs 0 the next cycle, no further sweep writes, timer restarts from 0.
